// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- registered integer ALU for the execute stage.
//
// Combines operands A and B under a 3-bit opcode. The result and status flags
// are registered on the rising edge of clk whenever in_valid is high.
// out_valid marks the cycle in which the registered values came from an
// accepted input. When in_valid is low at an edge, result and flags keep their
// value and out_valid drops.
//
// Configuration macro:
//   ALU_SHIFT_EN  when defined, opcodes 110/111 perform SLL/SRL. When left
//                 undefined, no shifter is built and those opcodes give
//                 result=0 with zero=1.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous active-high reset; clears all outputs
//   in_valid    in   1      A/B/ALUControl valid this cycle
//   A, B        in   WIDTH  operands
//   ALUControl  in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                           101 SLT, 110 SLL, 111 SRL
//   result      out  WIDTH  registered result
//   out_valid   out  1      result/flags updated from an accepted input
//   zero        out  1      result == 0
//   negative    out  1      result MSB
//   carry       out  1      ADD carry-out; SUB/SLT no-borrow (A >= B unsigned)
//   overflow    out  1      signed overflow for ADD/SUB/SLT
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
`ifdef ALU_SHIFT_EN
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;
  localparam int         SHW    = $clog2(WIDTH);
`endif

  logic             w_is_sub;
  logic             w_is_arith;
  logic [WIDTH-1:0] w_b_op;
  logic [WIDTH:0]   w_sum;
  logic             w_add_ovf;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_overflow;

  logic [WIDTH-1:0] r_result;
  logic             r_valid;
  logic             r_zero;
  logic             r_negative;
  logic             r_carry;
  logic             r_overflow;

`ifdef ALU_SHIFT_EN
  logic [SHW-1:0]   w_shamt;
  assign w_shamt = B[SHW-1:0];
`endif

  // SUB and SLT share the adder: A + ~B + 1. The carry-out of that sum is
  // the "no borrow" flag, i.e. A >= B unsigned.
  assign w_is_sub   = (ALUControl == OP_SUB) || (ALUControl == OP_SLT);
  assign w_is_arith = w_is_sub || (ALUControl == OP_ADD);
  assign w_b_op     = w_is_sub ? ~B : B;
  assign w_sum      = {1'b0, A} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};
  assign w_add_ovf  = (A[WIDTH-1] == w_b_op[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    w_result = '0;
    case (ALUControl)
      OP_ADD:  w_result = w_sum[WIDTH-1:0];
      OP_SUB:  w_result = w_sum[WIDTH-1:0];
      OP_AND:  w_result = A & B;
      OP_OR:   w_result = A | B;
      OP_XOR:  w_result = A ^ B;
      // Sign of the difference corrected by overflow gives signed A < B.
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};
`ifdef ALU_SHIFT_EN
      OP_SLL:  w_result = A << w_shamt;
      OP_SRL:  w_result = A >> w_shamt;
`endif
      default: w_result = '0;
    endcase
  end

  assign w_carry    = w_is_arith ? w_sum[WIDTH] : 1'b0;
  assign w_overflow = w_is_arith ? w_add_ovf    : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result   <= '0;
      r_valid    <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result   <= w_result;
        r_zero     <= (w_result == '0);
        r_negative <= w_result[WIDTH-1];
        r_carry    <= w_carry;
        r_overflow <= w_overflow;
      end
    end
  end

  assign result    = r_result;
  assign out_valid = r_valid;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign carry     = r_carry;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUControl;
  logic [31:0] result;
  logic        out_valid;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;

  int   n_vec;
  int   n_err;
  exp_t sb_q[$];
  exp_t last_e;
  vec_t tbl[16];

  alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
    .ALUControl(ALUControl), .result(result), .out_valid(out_valid),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic [31:0] r, logic z, logic n, logic c, logic v);
    exp_t e;
    e.res = r; e.z = z; e.n = n; e.c = c; e.v = v;
    return e;
  endfunction

  function automatic vec_t mv(logic [2:0] op, logic [31:0] a, logic [31:0] b, exp_t e);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.e = e;
    return t;
  endfunction

  // Reference model for random vectors.
  function automatic exp_t model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    e = '0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[31:0];
        e.c = s[32];
        e.v = (a[31] == b[31]) && (e.res[31] != a[31]);
      end
      3'd1: begin
        e.res = a - b;
        e.c = (a >= b);
        e.v = (a[31] != b[31]) && (e.res[31] != a[31]);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: begin
        e.res = {31'd0, ($signed(a) < $signed(b))};
        e.c = (a >= b);
        e.v = (a[31] != b[31]) && ((a - b) >> 31 != {31'd0, a[31]});
      end
`ifdef ALU_SHIFT_EN
      3'd6: e.res = a << b[4:0];
      3'd7: e.res = a >> b[4:0];
`else
      default: e.res = 32'd0;
`endif
    endcase
    e.z = (e.res == 32'd0);
    e.n = e.res[31];
    return e;
  endfunction

  task automatic cmp(string name, exp_t exp_v, logic exp_valid);
    exp_t act;
    act = '{res: result, z: zero, n: negative, c: carry, v: overflow};
    n_vec++;
    if (act !== exp_v || out_valid !== exp_valid) begin
      n_err++;
      $display("FAIL %s: got res=%h z=%b n=%b c=%b v=%b valid=%b, want res=%h z=%b n=%b c=%b v=%b valid=%b",
               name, act.res, act.z, act.n, act.c, act.v, out_valid,
               exp_v.res, exp_v.z, exp_v.n, exp_v.c, exp_v.v, exp_valid);
    end
  endtask

  // Drive one cycle at the negedge, let the posedge capture, check #1 after.
  task automatic step(string name, logic v, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                      exp_t e);
    @(negedge clk);
    in_valid = v; ALUControl = op; A = a; B = b;
    if (v) sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (v) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL %s: scoreboard empty", name);
      end else begin
        last_e = sb_q.pop_front();
        cmp(name, last_e, 1'b1);
      end
    end else begin
      cmp(name, last_e, 1'b0);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; ALUControl = '0;
    last_e = '0;

    tbl[0]  = mv(3'd0, 32'd25342, 32'd0, mk(32'd25342, 0, 0, 0, 0));
    tbl[1]  = mv(3'd1, 32'd2134, 32'd2134, mk(32'd0, 1, 0, 1, 0));
    tbl[2]  = mv(3'd2, 32'd56431, 32'd343455, mk(32'd7183, 0, 0, 0, 0));
    tbl[3]  = mv(3'd3, 32'd1433, 32'd39435, mk(32'd40859, 0, 0, 0, 0));
    tbl[4]  = mv(3'd4, 32'd1, 32'd12355, mk(32'd12354, 0, 0, 0, 0));
    tbl[5]  = mv(3'd5, 32'd1, 32'd1, mk(32'd0, 1, 0, 1, 0));
    tbl[6]  = mv(3'd5, 32'hFFFFFFFF, 32'd1, mk(32'd1, 0, 0, 1, 0));
    tbl[7]  = mv(3'd0, 32'h7FFFFFFF, 32'd1, mk(32'h80000000, 0, 1, 0, 1));
    tbl[8]  = mv(3'd0, 32'hFFFFFFFF, 32'd1, mk(32'd0, 1, 0, 1, 0));
    tbl[9]  = mv(3'd1, 32'd0, 32'd1, mk(32'hFFFFFFFF, 0, 1, 0, 0));
    tbl[10] = mv(3'd1, 32'h80000000, 32'd1, mk(32'h7FFFFFFF, 0, 0, 1, 1));
    tbl[11] = mv(3'd5, 32'h80000000, 32'h7FFFFFFF, mk(32'd1, 0, 0, 1, 1));
`ifdef ALU_SHIFT_EN
    tbl[12] = mv(3'd6, 32'd1, 32'd4, mk(32'd16, 0, 0, 0, 0));
    tbl[13] = mv(3'd7, 32'h80000000, 32'd31, mk(32'd1, 0, 0, 0, 0));
    tbl[14] = mv(3'd6, 32'h00001234, 32'd32, mk(32'h00001234, 0, 0, 0, 0));
    tbl[15] = mv(3'd7, 32'hFFFFFFFF, 32'd4, mk(32'h0FFFFFFF, 0, 0, 0, 0));
`else
    tbl[12] = mv(3'd6, 32'd1, 32'd4, mk(32'd0, 1, 0, 0, 0));
    tbl[13] = mv(3'd7, 32'h80000000, 32'd31, mk(32'd0, 1, 0, 0, 0));
    tbl[14] = mv(3'd6, 32'h00001234, 32'd32, mk(32'd0, 1, 0, 0, 0));
    tbl[15] = mv(3'd7, 32'hFFFFFFFF, 32'd4, mk(32'd0, 1, 0, 0, 0));
`endif

    #1;
    cmp("reset_state", '0, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed table, back to back.
    foreach (tbl[i])
      step($sformatf("tbl%0d", i), 1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);

    // Idle cycle with garbage inputs: result and flags hold.
    step("hold_tbl", 1'b0, 3'd0, 32'hDEAD_BEEF, 32'h1234_5678, '0);

    // Random vectors mixed with idle cycles.
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic        v;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 3 == 0) ? a : $urandom;
      v  = ($urandom_range(0, 4) != 0);
      step($sformatf("rnd%0d", i), v, op, a, b, model(op, a, b));
    end

    // Asynchronous reset between edges, mid-stream.
    step("pre_reset", 1'b1, 3'd0, 32'd5, 32'd6, mk(32'd11, 0, 0, 0, 0));
    @(negedge clk);
    in_valid = 1'b1; ALUControl = 3'd0; A = 32'h7FFFFFFF; B = 32'd1;
    #2;
    rst = 1'b1;
    #1;
    last_e = '0;
    cmp("async_reset", last_e, 1'b0);
    @(posedge clk);
    #1;
    cmp("input_during_reset", last_e, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    step("hold_after_reset", 1'b0, 3'd1, 32'd3, 32'd9, '0);
    step("first_after_reset", 1'b1, 3'd1, 32'd3, 32'd9, mk(32'hFFFFFFFA, 0, 1, 0, 0));
    step("hold_final", 1'b0, 3'd4, 32'd0, 32'd0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
